// File: rtl/converter_sample_scheduler.sv
// Periodic converter enable / settle / capture sequencer with a small sample FIFO.
// Optional over-voltage trip (TRIP state, ovp_thresh/ovp_trip ports) enabled by OVP_TRIP_EN.
module converter_sample_scheduler #(
  parameter int PERIOD_W   = 8,
  parameter int SETTLE_CYC = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [PERIOD_W-1:0] period,
  output logic                conv_en,
  input  logic [DATA_W-1:0]   conv_data,
  output logic [DATA_W-1:0]   sample_data,
  output logic                sample_valid,
  input  logic                sample_ready,
`ifdef OVP_TRIP_EN
  input  logic [DATA_W-1:0]   ovp_thresh,
  output logic                ovp_trip,
`endif
  output logic                overrun,
  output logic                busy
);

  // state    | meaning
  // S_IDLE   | stopped, converter off, sticky flags cleared
  // S_WAIT   | counting max(period,1) idle cycles
  // S_SETTLE | converter on, waiting SETTLE_CYC cycles
  // S_CAPTURE| converter on, conv_data pushed this cycle
  // S_TRIP   | over-voltage seen, converter held off until ena drops
`ifdef OVP_TRIP_EN
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SETTLE, S_CAPTURE, S_TRIP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SETTLE, S_CAPTURE} state_t;
`endif

  localparam int SW    = $clog2(SETTLE_CYC + 1);
  localparam int CNT_W = (PERIOD_W > SW) ? PERIOD_W : SW;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]   w_period_eff;
  logic               w_push, w_pop, w_full, w_wr;
  logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr, r_rd_ptr, w_rd_ptr_inc;
  logic [CW-1:0]      r_count;
  logic [DATA_W-1:0]  r_sample_data, w_head_nxt;
  logic               r_overrun;
`ifdef OVP_TRIP_EN
  logic               r_ovp_trip, w_trip_set;
`endif

  assign w_period_eff = (period == '0) ? CNT_W'(1) : CNT_W'(period);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
`ifdef OVP_TRIP_EN
    w_trip_set  = 1'b0;
`endif
    if (!ena) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = w_period_eff;
        end
        S_WAIT: begin
          if (r_cnt <= CNT_W'(1)) begin
            w_state_nxt = S_SETTLE;
            w_cnt_nxt   = CNT_W'(SETTLE_CYC);
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        S_SETTLE: begin
          if (r_cnt <= CNT_W'(1)) w_state_nxt = S_CAPTURE;
          else                    w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
        S_CAPTURE: begin
          w_push      = 1'b1;
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = w_period_eff;
`ifdef OVP_TRIP_EN
          if (conv_data > ovp_thresh) begin
            w_state_nxt = S_TRIP;
            w_trip_set  = 1'b1;
          end
`endif
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  assign conv_en = (r_state == S_SETTLE) || (r_state == S_CAPTURE);
  assign busy    = (r_state != S_IDLE);

  assign sample_valid = (r_count != '0);
  assign sample_data  = r_sample_data;
  assign overrun      = r_overrun;
  assign w_pop        = sample_valid & sample_ready;
  assign w_full       = (r_count == CW'(FIFO_DEPTH));
  assign w_wr         = w_push & (~w_full | w_pop);
  assign w_rd_ptr_inc = r_rd_ptr + AW'(1);

  // Head register follows the entry behind the popped one, or the incoming
  // sample when the queue is (or becomes) empty at the same moment.
  always_comb begin
    w_head_nxt = r_sample_data;
    if (w_pop) begin
      if (r_count != CW'(1)) w_head_nxt = r_mem[w_rd_ptr_inc];
      else if (w_wr)         w_head_nxt = conv_data;
    end else if (w_wr && (r_count == '0)) begin
      w_head_nxt = conv_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= conv_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_sample_data <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_sample_data <= w_head_nxt;
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= w_rd_ptr_inc;
      if (w_wr && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_wr && w_pop) r_count <= r_count - CW'(1);
      if (r_state == S_IDLE)                r_overrun <= 1'b0;
      else if (w_push && w_full && !w_pop)  r_overrun <= 1'b1;
    end
  end

`ifdef OVP_TRIP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_ovp_trip <= 1'b0;
    else if (r_state == S_IDLE) r_ovp_trip <= 1'b0;
    else if (w_trip_set)        r_ovp_trip <= 1'b1;
  end
  assign ovp_trip = r_ovp_trip;
`endif

endmodule
